// File: rtl/tile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tile_writeback
// Purpose  : Collects one tile of blended signed fixed-point samples,
//            quantizes each to an 8-bit intensity and streams the tile out
//            with absolute pixel coordinates. Two ping-pong banks let the
//            next tile fill while the previous one drains.
// Ports    : clk, rst          - single clock, synchronous active-high reset
//            in_valid/in_ready - sample handshake; in_data, in_last, and
//                                tile_x/tile_y (latched on a tile's 1st sample)
//            out_valid/out_ready - pixel handshake; out_pixel, out_x, out_y,
//                                out_last (final pixel of the draining tile)
//            short_tile        - sticky: a tile closed early on in_last
// Options  : TILE_WB_SHORT_PAD_EN - when defined, short tiles drain all
//            TILE_SIZE*TILE_SIZE pixels, zero-filled past the stored count.
// Revision : 1.0 - initial release
// ============================================================================
module tile_writeback #(
  parameter int TILE_SIZE   = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int FRAC_BITS   = 16,
  parameter int COORD_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_last,
  input  logic [COORD_WIDTH-1:0] tile_x,
  input  logic [COORD_WIDTH-1:0] tile_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_pixel,
  output logic [COORD_WIDTH-1:0] out_x,
  output logic [COORD_WIDTH-1:0] out_y,
  output logic                   out_last,
  output logic                   short_tile
);

  localparam int N     = TILE_SIZE * TILE_SIZE;
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(N + 1);
  localparam int POS_W = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(TILE_SIZE - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  typedef enum logic [0:0] {
    DRAIN_IDLE   = 1'b0,
    DRAIN_ACTIVE = 1'b1
  } drain_state_e;

  // Per-bank storage and bookkeeping
  logic [7:0]             mem_q      [2][N];
  bank_state_e            bank_st_q  [2];
  logic [CNT_W-1:0]       bank_cnt_q [2];
  logic [COORD_WIDTH-1:0] bank_x_q   [2];
  logic [COORD_WIDTH-1:0] bank_y_q   [2];

  // Fill side
  logic             wp_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic             short_q;

  // Drain side
  logic             rp_q;
  drain_state_e     drain_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic [POS_W-1:0] col_q;
  logic [POS_W-1:0] row_q;
  logic             out_valid_q;
  logic [7:0]       out_pixel_q;
  logic [COORD_WIDTH-1:0] out_x_q;
  logic [COORD_WIDTH-1:0] out_y_q;
  logic             out_last_q;

  // --------------------------------------------------------------------------
  // Quantization: negative -> 0, >= 1.0 -> 255, else top 8 fraction bits.
  // Any set integer bit on a non-negative sample means the value is >= 1.0.
  // --------------------------------------------------------------------------
  logic       w_neg;
  logic       w_sat;
  logic [7:0] w_qpix;

  assign w_neg  = in_data[DATA_WIDTH-1];
  assign w_sat  = |in_data[DATA_WIDTH-2:FRAC_BITS];
  assign w_qpix = w_neg ? 8'h00 : (w_sat ? 8'hFF : in_data[FRAC_BITS-1 -: 8]);

  generate
    if (FRAC_BITS > 8) begin : g_frac_sink
      // Fraction bits below the 8 kept ones are intentionally truncated.
      logic w_unused_frac;
      assign w_unused_frac = ^in_data[FRAC_BITS-9:0];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Fill control
  // --------------------------------------------------------------------------
  logic w_accept;
  logic w_close;

  assign in_ready = (bank_st_q[wp_q] == BANK_EMPTY) || (bank_st_q[wp_q] == BANK_FILLING);
  assign w_accept = in_valid && in_ready;
  assign w_close  = w_accept && (in_last || (wr_idx_q == LAST_IDX));

  always_ff @(posedge clk) begin
    if (w_accept) begin
      mem_q[wp_q][wr_idx_q] <= w_qpix;
    end
  end

  // --------------------------------------------------------------------------
  // Drain load selection: which bank/index (if any) gets registered onto the
  // output this cycle. Finishing one bank may directly load the other so
  // consecutive full banks stream without a bubble.
  // --------------------------------------------------------------------------
  logic             w_hs;
  logic             w_ld;
  logic             w_free;
  logic             w_ld_bank;
  logic [IDX_W-1:0] w_ld_idx;
  logic [POS_W-1:0] w_ld_col;
  logic [POS_W-1:0] w_ld_row;
  logic [CNT_W-1:0] w_ld_cnt;
  logic             w_ld_last;
  logic [7:0]       w_ld_pix;

  always_comb begin
    w_hs      = out_valid_q && out_ready;
    w_ld      = 1'b0;
    w_free    = 1'b0;
    w_ld_bank = rp_q;
    w_ld_idx  = '0;
    w_ld_col  = '0;
    w_ld_row  = '0;
    if (drain_q == DRAIN_IDLE) begin
      if (bank_st_q[rp_q] == BANK_FULL) begin
        w_ld = 1'b1;
      end
    end else if (w_hs) begin
      if (out_last_q) begin
        w_free    = 1'b1;
        w_ld_bank = ~rp_q;
        if (bank_st_q[~rp_q] == BANK_FULL) begin
          w_ld = 1'b1;
        end
      end else begin
        w_ld     = 1'b1;
        w_ld_idx = rd_idx_q + 1'b1;
        if (col_q == LAST_POS) begin
          w_ld_col = '0;
          w_ld_row = row_q + 1'b1;
        end else begin
          w_ld_col = col_q + 1'b1;
          w_ld_row = row_q;
        end
      end
    end
  end

  assign w_ld_cnt = bank_cnt_q[w_ld_bank];

`ifdef TILE_WB_SHORT_PAD_EN
  assign w_ld_last = (w_ld_idx == LAST_IDX);
  assign w_ld_pix  = (CNT_W'(w_ld_idx) >= w_ld_cnt) ? 8'h00 : mem_q[w_ld_bank][w_ld_idx];
`else
  // A closed tile always holds at least one sample, so count-1 never wraps.
  assign w_ld_last = (CNT_W'(w_ld_idx) == (w_ld_cnt - 1'b1));
  assign w_ld_pix  = mem_q[w_ld_bank][w_ld_idx];
`endif

  // --------------------------------------------------------------------------
  // Bank state, fill pointer and drain FSM. Fill only touches the bank at wp
  // (EMPTY/FILLING) and drain only touches FULL/DRAINING banks, so the two
  // sides never write the same bank state in one cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st_q[0]  <= BANK_EMPTY;
      bank_st_q[1]  <= BANK_EMPTY;
      bank_cnt_q[0] <= '0;
      bank_cnt_q[1] <= '0;
      bank_x_q[0]   <= '0;
      bank_x_q[1]   <= '0;
      bank_y_q[0]   <= '0;
      bank_y_q[1]   <= '0;
      wp_q          <= 1'b0;
      wr_idx_q      <= '0;
      short_q       <= 1'b0;
      rp_q          <= 1'b0;
      drain_q       <= DRAIN_IDLE;
      rd_idx_q      <= '0;
      col_q         <= '0;
      row_q         <= '0;
      out_valid_q   <= 1'b0;
      out_pixel_q   <= 8'h00;
      out_x_q       <= '0;
      out_y_q       <= '0;
      out_last_q    <= 1'b0;
    end else begin
      if (w_accept) begin
        if (bank_st_q[wp_q] == BANK_EMPTY) begin
          bank_x_q[wp_q]  <= tile_x;
          bank_y_q[wp_q]  <= tile_y;
          bank_st_q[wp_q] <= BANK_FILLING;
        end
        if (w_close) begin
          bank_cnt_q[wp_q] <= CNT_W'(wr_idx_q) + 1'b1;
          bank_st_q[wp_q]  <= BANK_FULL;
          wp_q             <= ~wp_q;
          wr_idx_q         <= '0;
          if (in_last && (wr_idx_q != LAST_IDX)) begin
            short_q <= 1'b1;
          end
        end else begin
          wr_idx_q <= wr_idx_q + 1'b1;
        end
      end

      if (w_free) begin
        bank_st_q[rp_q] <= BANK_EMPTY;
        rp_q            <= ~rp_q;
      end

      if (w_ld) begin
        bank_st_q[w_ld_bank] <= BANK_DRAINING;
        drain_q     <= DRAIN_ACTIVE;
        rd_idx_q    <= w_ld_idx;
        col_q       <= w_ld_col;
        row_q       <= w_ld_row;
        out_valid_q <= 1'b1;
        out_pixel_q <= w_ld_pix;
        out_x_q     <= bank_x_q[w_ld_bank] + COORD_WIDTH'(w_ld_col);
        out_y_q     <= bank_y_q[w_ld_bank] + COORD_WIDTH'(w_ld_row);
        out_last_q  <= w_ld_last;
      end else if (w_free) begin
        drain_q     <= DRAIN_IDLE;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign out_last   = out_last_q;
  assign short_tile = short_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_writeback
// Purpose  : Self-checking bench for tile_writeback (TILE_SIZE=4). Tiles are
//            described by sample lists; the expected pixel stream is derived
//            from the quantization and raster-coordinate rules and queued,
//            and a monitor pops and compares on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_writeback;

  localparam int T  = 4;
  localparam int N  = T * T;
  localparam int DW = 32;
  localparam int FB = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [CW-1:0] tile_x;
  logic [CW-1:0] tile_y;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_pixel;
  logic [CW-1:0] out_x;
  logic [CW-1:0] out_y;
  logic          out_last;
  logic          short_tile;

  tile_writeback #(
    .TILE_SIZE  (T),
    .DATA_WIDTH (DW),
    .FRAC_BITS  (FB),
    .COORD_WIDTH(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .tile_x    (tile_x),
    .tile_y    (tile_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_last  (out_last),
    .short_tile(short_tile)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]    p;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          l;
  } exp_t;

  exp_t          sb[$];
  logic [31:0]   pend_data[$];
  int            checks   = 0;
  int            failures = 0;
  int            acc_cnt  = 0;
  int            last_acc_cyc = 0;
  int            first_valid_cyc = 0;
  bit            lat_arm  = 0;
  bit            mon_en   = 0;
  int            rdy_mode = 0;
  bit            stall_done;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference quantizer, straight from the value ranges.
  function automatic logic [7:0] quant(input logic [31:0] d);
    if (d[31]) return 8'd0;
    if (d >= 32'h0001_0000) return 8'd255;
    return 8'(d / 256);
  endfunction

  function automatic logic [31:0] rand_sample();
    case ($urandom % 4)
      0:       return {1'b1, 31'($urandom)};
      1:       return 32'($urandom_range(32'h0001_0000, 32'h7FFF_FFFF));
      default: return 32'($urandom % 65536);
    endcase
  endfunction

  // Expected output stream of one tile given its quantized samples.
  task automatic push_expected(input logic [CW-1:0] tx, input logic [CW-1:0] ty,
                               input logic [7:0] px[$]);
    exp_t e;
    int   emit;
`ifdef TILE_WB_SHORT_PAD_EN
    emit = N;
`else
    emit = px.size();
`endif
    for (int i = 0; i < emit; i++) begin
      e.p = (i < px.size()) ? px[i] : 8'd0;
      e.x = tx + CW'(i % T);
      e.y = ty + CW'(i / T);
      e.l = (i == emit - 1);
      sb.push_back(e);
    end
  endtask

  // Offer one sample until accepted (bounded). Called at posedge+#1.
  task automatic send(input logic [31:0] d, input logic l,
                      input logic [CW-1:0] tx, input logic [CW-1:0] ty);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tile_x   = tx;
    tile_y   = ty;
    while (!in_ready && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 1, 0);
      in_valid = 1'b0;
    end else begin
      last_acc_cyc = cyc;
      @(posedge clk); #1;
      acc_cnt++;
    end
  endtask

  // Send a tile of n samples (data from pend_data, else random). Origin is
  // only valid on the first sample to confirm the DUT latches it.
  task automatic send_tile(input logic [CW-1:0] tx, input logic [CW-1:0] ty,
                           input int n, input bit gaps);
    logic [31:0] dq[$];
    logic [7:0]  px[$];
    logic        l;
    for (int i = 0; i < n; i++) begin
      dq.push_back((pend_data.size() > 0) ? pend_data.pop_front() : rand_sample());
      px.push_back(quant(dq[i]));
    end
    push_expected(tx, ty, px);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom % 4 == 0)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (i == n - 1) l = (n < N) ? 1'b1 : 1'($urandom % 2);
      else            l = 1'b0;
      if (i == 0) send(dq[i], l, tx, ty);
      else        send(dq[i], l, CW'($urandom), CW'($urandom));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("queue_empty", sb.size(), 0);
  endtask

  // out_ready driver: 0 = held high, 1 = held low, else random.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom % 2);
      endcase
    end
  end

  // Monitor: stall-hold check and scoreboard compare on each handshake.
  exp_t          e_m;
  bit            stall_prev = 0;
  logic [41:0]   prev_out;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (stall_prev)
        check("hold_while_stalled", {out_valid, out_pixel, out_x, out_y, out_last}, prev_out);
      if (lat_arm && out_valid) begin
        first_valid_cyc = cyc;
        lat_arm = 0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_pixel", 1, 0);
        end else begin
          e_m = sb.pop_front();
          check("out_pixel", out_pixel, e_m.p);
          check("out_x", out_x, e_m.x);
          check("out_y", out_y, e_m.y);
          check("out_last", out_last, e_m.l);
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_out   = {out_valid, out_pixel, out_x, out_y, out_last};
    end
  end

  initial begin
    bit found;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    tile_x   = '0;
    tile_y   = '0;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pixel", out_pixel, 0);
    check("rst_out_xy", {out_x, out_y}, 0);
    check("rst_out_last", out_last, 0);
    check("rst_short_tile", short_tile, 0);
    check("rst_in_ready", in_ready, 1);
    mon_en = 1;

    // Mid-gray tile at (32,48), drain latency measured from the last accept.
    for (int i = 0; i < N; i++) pend_data.push_back(32'h0000_8000);
    lat_arm = 1;
    send_tile(16'd32, 16'd48, N, 0);
    wait_drain();
    check("first_valid_latency", first_valid_cyc - last_acc_cyc, 2);

    // Quantization corners.
    pend_data.push_back(32'hFFFF_FFFF);
    pend_data.push_back(32'h0000_0000);
    pend_data.push_back(32'h0000_00FF);
    pend_data.push_back(32'h0001_0000);
    pend_data.push_back(32'h7FFF_FFFF);
    pend_data.push_back(32'h0000_FFFF);
    send_tile(16'd4, 16'd8, N, 0);
    wait_drain();

    // Three tiles against a blocked output: only two banks can fill.
    rdy_mode   = 1;
    acc_cnt    = 0;
    stall_done = 0;
    fork
      begin
        send_tile(16'd0,  16'd0,  N, 0);
        send_tile(16'd64, 16'd16, N, 0);
        send_tile(16'd128, 16'd32, N, 0);
        stall_done = 1;
      end
    join_none
    repeat (60) @(posedge clk);
    #1;
    check("stall_accepts", acc_cnt, 32);
    check("stall_in_ready", in_ready, 0);
    rdy_mode = 0;
    found = 0;
    for (int k = 0; k < 500 && !found; k++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_last) found = 1;
    end
    check("first_bank_drained", found, 1);
    check("in_ready_before_free", in_ready, 0);
    @(posedge clk); #1;
    check("in_ready_after_free", in_ready, 1);
    for (int k = 0; k < 3000 && !stall_done; k++) @(posedge clk);
    #1;
    check("stall_sender_done", stall_done, 1);
    wait_drain();

    // Short tile: in_last on index 4.
    check("short_tile_clear", short_tile, 0);
    send_tile(16'd60, 16'd70, 5, 0);
    check("short_tile_set", short_tile, 1);
    wait_drain();

    // Random tiles, random gaps, random backpressure.
    rdy_mode = 2;
    for (int t = 0; t < 8; t++) begin
      send_tile(CW'($urandom % 1000), CW'($urandom % 1000),
                ($urandom % 3 == 0) ? int'($urandom_range(1, N - 1)) : N, 1);
    end
    wait_drain();
    rdy_mode = 0;

    // Reset mid-drain of tile A with tile B partially filled.
    rdy_mode = 1;
    send_tile(16'd100, 16'd200, N, 0);
    for (int i = 0; i < 6; i++) send(rand_sample(), 1'b0, 16'd300, 16'd400);
    in_valid = 1'b0;
    rdy_mode = 0;
    repeat (5) @(posedge clk);
    #1;
    mon_en = 0;
    rst    = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    stall_prev = 0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_short_tile", short_tile, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_last", out_last, 0);
    mon_en = 1;
    send_tile(16'd8, 16'd12, N, 0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
